// File: rtl/hyperbus_pkg.sv
// Shared Hyperbus payload types: timing config and per-chip address rules.
package hyperbus_pkg;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [3:0]  t_tx_clk_delay;
    logic [4:0]  address_mask_msb;
    logic        address_space;
  } hyper_cfg_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } hyper_rule_t;

endpackage

// File: rtl/hyperbus_cfg_shadow.sv
// Shadow registers for Hyperbus config and chip rules; applies register-file changes
// atomically while the engine is idle, then holds off new transactions for a settle window.
module hyperbus_cfg_shadow
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips     = 2,
  parameter type         rule_t       = hyper_rule_t,
  parameter int unsigned SettleCycles = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  hyper_cfg_t                 cfg_i,
  input  rule_t [NumChips-1:0]       chip_rules_i,
  input  logic                       phy_busy_i,
  output hyper_cfg_t                 cfg_o,
  output rule_t [NumChips-1:0]       chip_rules_o,
  output logic                       hold_o,
  output logic                       cfg_applied_o,
  output logic [15:0]                apply_count_o
);

  localparam int unsigned CntW = 8;
  localparam bit HasSettle = (SettleCycles != 0);
  localparam logic [CntW-1:0] SettleLoad = HasSettle ? CntW'(SettleCycles - 1) : '0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_GUARD,
    ST_WAIT_IDLE,
    ST_SETTLE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_c;
  logic            diff_c;

  // Any bit difference between the live and shadowed views triggers an update.
  assign diff_c = ({cfg_i, chip_rules_i} != {cfg_o, chip_rules_o});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        load_c  = 1'b1;
        cnt_d   = SettleLoad;
        state_d = HasSettle ? ST_SETTLE : ST_IDLE;
      end
      ST_IDLE: begin
        if (diff_c) state_d = ST_GUARD;
      end
      // Covers a transaction the engine accepted in the detect cycle.
      ST_GUARD: begin
        state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!phy_busy_i) begin
          load_c  = 1'b1;
          cnt_d   = SettleLoad;
          state_d = HasSettle ? ST_SETTLE : ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      cfg_o         <= '0;
      chip_rules_o  <= '0;
      hold_o        <= 1'b1;
      cfg_applied_o <= 1'b0;
      apply_count_o <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_o        <= (state_d != ST_IDLE);
      cfg_applied_o <= load_c;
      if (load_c) begin
        cfg_o         <= cfg_i;
        chip_rules_o  <= chip_rules_i;
        apply_count_o <= apply_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_cfg_shadow.sv
// Randomised directed bench for hyperbus_cfg_shadow against a transaction-level expectation model.
module tb_hyperbus_cfg_shadow;
  import hyperbus_pkg::*;

  localparam int unsigned NUM_CHIPS = 2;
  localparam int unsigned SETTLE    = 8;

  typedef hyper_rule_t [NUM_CHIPS-1:0] rules_t;

  localparam int unsigned CW = $bits(hyper_cfg_t);
  localparam int unsigned RW = $bits(rules_t);

  logic        clk = 1'b0;
  logic        rst_n;
  hyper_cfg_t  cfg_i, cfg_o;
  rules_t      rules_i, rules_o;
  logic        busy;
  logic        hold;
  logic        applied;
  logic [15:0] apply_cnt;

  int checks = 0;
  int errors = 0;

  hyper_cfg_t  exp_cfg;
  rules_t      exp_rules;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  hyperbus_cfg_shadow #(
    .NumChips    (NUM_CHIPS),
    .rule_t      (hyper_rule_t),
    .SettleCycles(SETTLE)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_i        (cfg_i),
    .chip_rules_i (rules_i),
    .phy_busy_i   (busy),
    .cfg_o        (cfg_o),
    .chip_rules_o (rules_o),
    .hold_o       (hold),
    .cfg_applied_o(applied),
    .apply_count_o(apply_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic hyper_cfg_t rand_cfg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CW-1:0];
  endfunction

  function automatic rules_t rand_rules();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r[RW-1:0];
  endfunction

  task automatic chk_shadow(input string tag);
    chk({tag, ".cfg"},   256'(cfg_o),   256'(exp_cfg));
    chk({tag, ".rules"}, 256'(rules_o), 256'(exp_rules));
  endtask

  // Drive a new config from IDLE; expect GUARD, WAIT_IDLE (busy_cyc extra busy cycles), then the apply.
  task automatic apply_phase(input string tag, input hyper_cfg_t c_new, input rules_t r_new,
                             input int busy_cyc, input bit mid, input hyper_cfg_t c_mid);
    cfg_i   = c_new;
    rules_i = r_new;
    busy    = (busy_cyc > 0);
    tick();
    chk({tag, ".guard_hold"}, 256'(hold), 256'(1'b1));
    chk({tag, ".guard_pulse"}, 256'(applied), 256'(1'b0));
    chk_shadow({tag, ".guard"});
    tick();
    chk({tag, ".wait_hold"}, 256'(hold), 256'(1'b1));
    chk_shadow({tag, ".wait"});
    if (mid) cfg_i = c_mid;
    for (int i = 0; i < busy_cyc; i++) begin
      tick();
      chk({tag, ".busy_hold"}, 256'(hold), 256'(1'b1));
      chk({tag, ".busy_pulse"}, 256'(applied), 256'(1'b0));
      chk_shadow({tag, ".busy"});
    end
    busy = 1'b0;
    tick();
    exp_cfg   = cfg_i;
    exp_rules = rules_i;
    exp_cnt   = exp_cnt + 16'd1;
    chk({tag, ".apply_pulse"}, 256'(applied), 256'(1'b1));
    chk({tag, ".apply_count"}, 256'(apply_cnt), 256'(exp_cnt));
    chk({tag, ".apply_hold"}, 256'(hold), 256'(1'b1));
    chk_shadow({tag, ".apply"});
  endtask

  // From the apply sample, hold stays high SETTLE-1 further cycles with no new pulse.
  task automatic settle_phase(input string tag, input bit chg, input hyper_cfg_t c_chg,
                              input bit revert);
    int high;
    int pulses;
    high   = 0;
    pulses = 0;
    if (chg) cfg_i = c_chg;
    for (int i = 0; i < int'(SETTLE) + 4; i++) begin
      tick();
      pulses += int'(applied);
      if (hold !== 1'b1) break;
      high++;
      if (revert && high == 2) cfg_i = exp_cfg;
    end
    chk({tag, ".settle_len"}, 256'(high), 256'(SETTLE - 1));
    chk({tag, ".settle_pulses"}, 256'(pulses), 256'(0));
    chk({tag, ".idle_hold"}, 256'(hold), 256'(1'b0));
    chk({tag, ".idle_count"}, 256'(apply_cnt), 256'(exp_cnt));
    chk_shadow({tag, ".idle"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    hyper_cfg_t  c, c2;
    rules_t      r;
    logic [15:0] cnt0;

    rst_n   = 1'b0;
    busy    = 1'b0;
    c       = rand_cfg();
    c.t_burst_max    = 16'd665;
    c.t_rx_clk_delay = 4'd8;
    cfg_i   = c;
    rules_i = rand_rules();
    exp_cfg   = '0;
    exp_rules = '0;
    exp_cnt   = '0;

    // Reset state
    tick();
    tick();
    chk_shadow("reset");
    chk("reset.hold", 256'(hold), 256'(1'b1));
    chk("reset.pulse", 256'(applied), 256'(1'b0));
    chk("reset.count", 256'(apply_cnt), 256'(16'd0));

    // First clock after release loads unconditionally
    rst_n = 1'b1;
    tick();
    exp_cfg   = cfg_i;
    exp_rules = rules_i;
    exp_cnt   = 16'd1;
    chk_shadow("init");
    chk("init.burst_max", 256'(cfg_o.t_burst_max), 256'(16'd665));
    chk("init.pulse", 256'(applied), 256'(1'b1));
    chk("init.count", 256'(apply_cnt), 256'(16'd1));
    chk("init.hold", 256'(hold), 256'(1'b1));
    settle_phase("init", 1'b0, c, 1'b0);

    // rx delay 8 -> 5 with engine idle
    c = exp_cfg;
    c.t_rx_clk_delay = 4'd5;
    apply_phase("rxdly", c, exp_rules, 0, 1'b0, c);
    chk("rxdly.value", 256'(cfg_o.t_rx_clk_delay), 256'(4'd5));
    settle_phase("rxdly", 1'b0, c, 1'b0);

    // chip 1 end_addr change while busy for 20 cycles
    r = exp_rules;
    r[1].end_addr = r[1].end_addr ^ 32'h00F0_0000;
    apply_phase("busy20", exp_cfg, r, 18, 1'b0, exp_cfg);
    settle_phase("busy20", 1'b0, exp_cfg, 1'b0);

    // latency 6, then 7 -> 9 during WAIT_IDLE gives one apply with 9
    c = exp_cfg;
    c.t_latency_access = 4'd6;
    apply_phase("lat6", c, exp_rules, 0, 1'b0, c);
    settle_phase("lat6", 1'b0, c, 1'b0);
    cnt0 = apply_cnt;
    c.t_latency_access  = 4'd7;
    c2 = c;
    c2.t_latency_access = 4'd9;
    apply_phase("lat9", c, exp_rules, 3, 1'b1, c2);
    chk("lat9.value", 256'(cfg_o.t_latency_access), 256'(4'd9));
    chk("lat9.count_step", 256'(apply_cnt), 256'(cnt0 + 16'd1));
    settle_phase("lat9", 1'b0, c2, 1'b0);

    // tx delay change during SETTLE gives a back-to-back second update
    cnt0 = apply_cnt;
    c = exp_cfg;
    c.t_read_write_recovery = ~c.t_read_write_recovery;
    apply_phase("txa", c, exp_rules, 0, 1'b0, c);
    c2 = exp_cfg;
    c2.t_tx_clk_delay = ~c2.t_tx_clk_delay;
    settle_phase("txa", 1'b1, c2, 1'b0);
    apply_phase("txb", c2, exp_rules, 0, 1'b0, c2);
    settle_phase("txb", 1'b0, c2, 1'b0);
    chk("tx.count_step", 256'(apply_cnt), 256'(cnt0 + 16'd2));

    // change during SETTLE that reverts before IDLE: no further apply
    c = exp_cfg;
    c.address_space = ~c.address_space;
    apply_phase("rev", c, exp_rules, 1, 1'b0, c);
    c2 = exp_cfg;
    c2.t_burst_max = c2.t_burst_max + 16'd1;
    settle_phase("rev", 1'b1, c2, 1'b1);
    cnt0 = apply_cnt;
    repeat (4) begin
      tick();
      chk("rev.quiet_hold", 256'(hold), 256'(1'b0));
      chk("rev.quiet_pulse", 256'(applied), 256'(1'b0));
    end
    chk("rev.quiet_count", 256'(apply_cnt), 256'(cnt0));

    // randomised updates
    for (int n = 0; n < 10; n++) begin
      int bc;
      bit md;
      c  = rand_cfg();
      r  = rand_rules();
      if ({c, r} == {exp_cfg, exp_rules}) c.t_burst_max = ~c.t_burst_max;
      c2 = rand_cfg();
      bc = int'($urandom_range(0, 4));
      md = 1'($urandom_range(0, 1));
      apply_phase("rand", c, r, bc, md, c2);
      settle_phase("rand", 1'b0, c, 1'b0);
    end

    // async reset during WAIT_IDLE
    cfg_i = rand_cfg();
    if (cfg_i == exp_cfg) cfg_i.address_space = ~cfg_i.address_space;
    busy  = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cfg   = '0;
    exp_rules = '0;
    chk_shadow("rstmid");
    chk("rstmid.hold", 256'(hold), 256'(1'b1));
    chk("rstmid.pulse", 256'(applied), 256'(1'b0));
    chk("rstmid.count", 256'(apply_cnt), 256'(16'd0));
    cfg_i = rand_cfg();
    #2;
    rst_n = 1'b1;
    tick();
    exp_cfg   = cfg_i;
    exp_rules = rules_i;
    exp_cnt   = 16'd1;
    chk_shadow("reload");
    chk("reload.pulse", 256'(applied), 256'(1'b1));
    chk("reload.count", 256'(apply_cnt), 256'(16'd1));
    busy = 1'b0;
    settle_phase("reload", 1'b0, cfg_i, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
